phase_sequencer: RTL and testbench



---
 rtl/phase_sequencer_pkg.sv | 29 ++
 rtl/phase_window_cmp.sv | 55 +++++
 rtl/phase_sequencer.sv | 126 ++++++++++++
 tb/tb_phase_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the multi-phase timing generator: sequencer states,
// reset-time period/window defaults and the channel-to-domain mapping.
package phase_seq_pkg;

    // Sequencer state codes, also presented on state_out.
    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } phase_state_e;

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    // Reset-time configuration for the default 4-channel, 8-bit build.
    localparam int          NCH_DEF    = 4;
    localparam int          CW_DEF     = 8;
    localparam logic [7:0]  PERIOD_DEF = 8'd11;
    localparam logic [31:0] RISE_DEF   = {8'd10, 8'd5, 8'd1, 8'd5};
    localparam logic [31:0] FALL_DEF   = {8'd11, 8'd7, 8'd2, 8'd7};

    // Which phase channel drives which control domain.
    localparam int CH_ALU    = 0;
    localparam int CH_FETCH  = 1;
    localparam int CH_MULDIV = 2;
    localparam int CH_REG    = 3;

endpackage

// File: rtl/phase_window_cmp.sv
// One phase channel: shadow and active rise/fall window registers plus the
// registered window compare against the shared period counter.
module phase_window_cmp #(
    parameter int            CW       = 8,
    parameter logic [CW-1:0] RISE_RST = '0,
    parameter logic [CW-1:0] FALL_RST = '0
) (
    input  logic          clk_100M,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_rise,
    input  logic [CW-1:0] wr_fall,
    input  logic [CW-1:0] cnt,
    input  logic          adv,
    input  logic          apply,
    output logic          phase
);

    logic [CW-1:0] rise_sh;
    logic [CW-1:0] fall_sh;
    logic [CW-1:0] rise_act;
    logic [CW-1:0] fall_act;

    // Shadow window: captures runtime writes, lost on reset.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            rise_sh <= RISE_RST;
            fall_sh <= FALL_RST;
        end else if (wr_en) begin
            rise_sh <= wr_rise;
            fall_sh <= wr_fall;
        end
    end

    // Active window: takes the pre-write shadow at the period boundary.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            rise_act <= RISE_RST;
            fall_act <= FALL_RST;
        end else if (apply) begin
            rise_act <= rise_sh;
            fall_act <= fall_sh;
        end
    end

    // Registered compare; holds its value whenever the counter is frozen.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
        end else if (adv) begin
            phase <= (rise_act <= cnt) && (cnt < fall_act);
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase timing generator: one shared period counter, NCH windowed
// phase enables, stall/step control and boundary-applied reconfiguration.
//
// Config write protocol: cfg_we / cfg_period_we are single-cycle strobes with
// no back-pressure; the payload is captured into the shadow on the same edge
// and is always accepted. It reaches the active copy only at the next wrap.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int                PERIOD_INIT_W = 0,
    parameter int                NCH           = NCH_DEF,
    parameter int                CW            = CW_DEF,
    parameter logic [CW-1:0]     PERIOD_INIT   = PERIOD_DEF,
    parameter logic [NCH*CW-1:0] RISE_INIT     = RISE_DEF,
    parameter logic [NCH*CW-1:0] FALL_INIT     = FALL_DEF
) (
    input  logic                   clk_100M,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   step_req,
    input  logic                   cfg_we,
    input  logic [$clog2(NCH)-1:0] cfg_ch,
    input  logic [CW-1:0]          cfg_rise,
    input  logic [CW-1:0]          cfg_fall,
    input  logic                   cfg_period_we,
    input  logic [CW-1:0]          cfg_period,
    output logic [NCH-1:0]         phase_out,
    output logic                   wrap,
    output logic [CW-1:0]          cnt_out,
    output logic                   cfg_pending,
    output logic [1:0]             state_out
);

    localparam int CHW = $clog2(NCH);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] per_act;
    logic [CW-1:0] per_sh;
    logic          adv;
    logic          wrap_edge;

    // RUN advances only while run stays high (freeze is immediate); STEP
    // always advances until its wrap.
    assign adv       = ((state == ST_RUN) && run) || (state == ST_STEP);
    assign wrap_edge = adv && (cnt == per_act - CW'(1));

    // Sequencer state machine.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HALT;
        end else begin
            case (state)
                ST_HALT: begin
                    if (run)           state <= ST_RUN;
                    else if (step_req) state <= ST_STEP;
                end
                ST_RUN: begin
                    if (!run) state <= ST_HALT;
                end
                ST_STEP: begin
                    if (run)            state <= ST_RUN;
                    else if (wrap_edge) state <= ST_HALT;
                end
                default: state <= ST_HALT;
            endcase
        end
    end

    // Period counter and the wrap pulse that follows the period-1 -> 0 edge.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_edge;
            if (wrap_edge) cnt <= '0;
            else if (adv)  cnt <= cnt + CW'(1);
        end
    end

    // Shadow/active period; shadow values below 2 are clamped to 2.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            per_sh  <= PERIOD_INIT;
            per_act <= PERIOD_INIT;
        end else begin
            if (cfg_period_we) per_sh <= (cfg_period < CW'(2)) ? CW'(2) : cfg_period;
            if (wrap_edge)     per_act <= per_sh;
        end
    end

    // Pending flag: a new write wins over a coincident apply.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            cfg_pending <= 1'b0;
        end else if (cfg_we || cfg_period_we) begin
            cfg_pending <= 1'b1;
        end else if (wrap_edge) begin
            cfg_pending <= 1'b0;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam logic [CHW-1:0] IDX = CHW'(i);
        phase_window_cmp #(
            .CW       (CW),
            .RISE_RST (RISE_INIT[i*CW +: CW]),
            .FALL_RST (FALL_INIT[i*CW +: CW])
        ) u_win (
            .clk_100M (clk_100M),
            .rst_n    (rst_n),
            .wr_en    (cfg_we && (cfg_ch == IDX)),
            .wr_rise  (cfg_rise),
            .wr_fall  (cfg_fall),
            .cnt      (cnt),
            .adv      (adv),
            .apply    (wrap_edge),
            .phase    (phase_out[i])
        );
    end

    assign cnt_out   = cnt;
    assign state_out = state;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios followed by random stimulus,
// all checked each cycle against a behavioural model of the sequencer.
module tb_phase_sequencer;

    logic       clk_100M = 1'b0;
    logic       rst_n;
    logic       run, step_req, cfg_we, cfg_period_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_rise, cfg_fall, cfg_period;
    logic [3:0] phase_out;
    logic       wrap, cfg_pending;
    logic [7:0] cnt_out;
    logic [1:0] state_out;

    int n_checks = 0;
    int n_pass   = 0;
    int wrap_seen = 0;

    // Model state: mode 0=halted, 1=running, 2=single-period step.
    int       m_mode, m_cnt, m_per, s_per;
    int       m_rise[4], m_fall[4], s_rise[4], s_fall[4];
    bit [3:0] m_phase;
    bit       m_wrap, m_pend;
    int       rise_def[4] = '{5, 1, 5, 10};
    int       fall_def[4] = '{7, 2, 7, 11};

    phase_sequencer dut (
        .clk_100M      (clk_100M),
        .rst_n         (rst_n),
        .run           (run),
        .step_req      (step_req),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_rise      (cfg_rise),
        .cfg_fall      (cfg_fall),
        .cfg_period_we (cfg_period_we),
        .cfg_period    (cfg_period),
        .phase_out     (phase_out),
        .wrap          (wrap),
        .cnt_out       (cnt_out),
        .cfg_pending   (cfg_pending),
        .state_out     (state_out)
    );

    // Clock generation.
    always #5 clk_100M = ~clk_100M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_per = 11; s_per = 11;
        m_phase = '0; m_wrap = 0; m_pend = 0;
        for (int i = 0; i < 4; i++) begin
            m_rise[i] = rise_def[i]; s_rise[i] = rise_def[i];
            m_fall[i] = fall_def[i]; s_fall[i] = fall_def[i];
        end
    endtask

    // One clock edge of the behavioural model, using the inputs now driven.
    task automatic model_step();
        bit moving, boundary;
        moving   = (m_mode == 1 && run) || (m_mode == 2);
        boundary = moving && (m_cnt == m_per - 1);
        if (moving) begin
            for (int i = 0; i < 4; i++)
                m_phase[i] = (m_cnt >= m_rise[i]) && (m_cnt < m_fall[i]);
            m_cnt = boundary ? 0 : m_cnt + 1;
        end
        m_wrap = boundary;
        if (boundary) begin
            m_per = s_per;
            for (int i = 0; i < 4; i++) begin
                m_rise[i] = s_rise[i];
                m_fall[i] = s_fall[i];
            end
        end
        if (cfg_we) begin
            s_rise[cfg_ch] = cfg_rise;
            s_fall[cfg_ch] = cfg_fall;
        end
        if (cfg_period_we) s_per = (cfg_period < 2) ? 2 : int'(cfg_period);
        if (cfg_we || cfg_period_we) m_pend = 1;
        else if (boundary)           m_pend = 0;
        if (m_mode == 0)      m_mode = run ? 1 : (step_req ? 2 : 0);
        else if (m_mode == 1) m_mode = run ? 1 : 0;
        else                  m_mode = run ? 1 : (boundary ? 0 : 2);
    endtask

    task automatic check_all();
        check("cnt_out",     32'(cnt_out),     32'(m_cnt));
        check("phase_out",   32'(phase_out),   32'(m_phase));
        check("wrap",        32'(wrap),        32'(m_wrap));
        check("cfg_pending", 32'(cfg_pending), 32'(m_pend));
        check("state_out",   32'(state_out),   32'(m_mode));
        if (wrap) wrap_seen++;
    endtask

    // Driver: check the current cycle, apply new inputs, advance the model.
    task automatic cyc(input logic r, input logic s, input logic we, input logic [1:0] ch,
                       input logic [7:0] rs, input logic [7:0] fs,
                       input logic pwe, input logic [7:0] ps);
        @(negedge clk_100M);
        check_all();
        run = r; step_req = s; cfg_we = we; cfg_ch = ch;
        cfg_rise = rs; cfg_fall = fs; cfg_period_we = pwe; cfg_period = ps;
        model_step();
    endtask

    task automatic idle(input logic r);
        cyc(r, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
    endtask

    task automatic run_until(input string tag, input int tgt);
        int k;
        for (k = 0; k < 300 && !(m_mode == 1 && m_cnt == tgt); k++) idle(1'b1);
        check(tag, 32'(k < 300), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        run = 0; step_req = 0; cfg_we = 0; cfg_ch = 0;
        cfg_rise = 0; cfg_fall = 0; cfg_period_we = 0; cfg_period = 0;
        model_reset();
        repeat (2) @(negedge clk_100M);
        check("rst_cnt", 32'(cnt_out), 32'd0);
        check("rst_state", 32'(state_out), 32'd0);
        rst_n = 1'b1;
        model_step();

        // Free run with default windows for two periods.
        repeat (24) idle(1'b1);

        // Freeze at cnt=6, then resume.
        run_until("reach_cnt6", 6);
        repeat (5) idle(1'b0);
        check("frz_cnt", 32'(cnt_out), 32'd6);
        check("frz_ch0", 32'(phase_out[0]), 32'd1);
        repeat (4) idle(1'b1);

        // Halt at cnt=0, then one step request.
        run_until("reach_cnt0", 0);
        repeat (3) idle(1'b0);
        wrap_seen = 0;
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
        repeat (16) idle(1'b0);
        check("step_wraps", 32'(wrap_seen), 32'd1);
        check("step_state", 32'(state_out), 32'd0);
        check("step_cnt", 32'(cnt_out), 32'd0);

        // Mid-period reconfiguration: period 5, ch1 window 0..3.
        run_until("reach_cnt3", 3);
        cyc(1'b1, 1'b0, 1'b1, 2'd1, 8'd0, 8'd3, 1'b1, 8'd5);
        idle(1'b1);
        check("wr_pending", 32'(cfg_pending), 32'd1);
        repeat (20) idle(1'b1);

        // Write coinciding with the apply edge.
        run_until("reach_last", m_per - 1);
        cyc(1'b1, 1'b0, 1'b1, 2'd2, 8'd1, 8'd4, 1'b0, 8'd0);
        idle(1'b1);
        check("coinc_pending", 32'(cfg_pending), 32'd1);
        repeat (12) idle(1'b1);

        // Period clamp and an empty window.
        cyc(1'b1, 1'b0, 1'b1, 2'd3, 8'd7, 8'd7, 1'b1, 8'd0);
        repeat (20) idle(1'b1);
        check("clamp_cnt_le1", 32'(cnt_out <= 8'd1), 32'd1);
        check("empty_ch3", 32'(phase_out[3]), 32'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cyc(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 15) == 0),
                logic'($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                8'($urandom_range(0, 12)), 8'($urandom_range(0, 14)),
                logic'($urandom_range(0, 19) == 0), 8'($urandom_range(0, 14)));
        end

        // Asynchronous reset in the middle of a cycle.
        @(negedge clk_100M);
        check_all();
        run = 0; step_req = 0; cfg_we = 0; cfg_period_we = 0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_cnt", 32'(cnt_out), 32'd0);
        check("arst_phase", 32'(phase_out), 32'd0);
        check("arst_pending", 32'(cfg_pending), 32'd0);
        check("arst_state", 32'(state_out), 32'd0);
        model_reset();
        @(negedge clk_100M);
        rst_n = 1'b1;
        model_step();
        repeat (30) idle(1'b1);
        for (int n = 0; n < 500; n++) begin
            cyc(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 15) == 0),
                logic'($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                8'($urandom_range(0, 12)), 8'($urandom_range(0, 14)),
                logic'($urandom_range(0, 19) == 0), 8'($urandom_range(0, 14)));
        end
        @(negedge clk_100M);
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
